// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the SPI slave receive path.
package spi_rx_pkg;

   localparam int SPI_DEFAULT_W = 16;

   typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} spi_rx_state_t;

   // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// One-register edge detector for a clk-synchronous level; reset value chosen per pin.
module spi_edge_detect #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic d_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) d_q <= RST_VAL;
      else          d_q <= d;
   end

   assign rise = d & ~d_q;
   assign fall = ~d & d_q;

endmodule

// File: rtl/spi_slave_rx16.sv
// SPI slave receiver: oversampled SCLK/CS edge recovery, word shifter and valid/ready output.
//
// state    | meaning
// ST_IDLE  | waiting for a CS falling edge
// ST_SHIFT | frame open, shifting MOSI on each sample edge
module spi_slave_rx16
   import spi_rx_pkg::*;
#(
   parameter int   DATA_W    = SPI_DEFAULT_W,
   parameter logic CPOL      = 1'b0,
   parameter logic CPHA      = 1'b0,
   parameter logic MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sclk_f,
   input  logic              cs_n_f,
   input  logic              mosi_f,
   input  logic              rx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              overrun,
   output logic              frame_err,
   output logic              busy
);

   localparam int              CNT_W       = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
   localparam logic            SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   spi_rx_state_t     state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] sr;
   logic [DATA_W-1:0] sr_next;
   logic              word_done;
   logic              sclk_rise, sclk_fall;
   logic              cs_rise, cs_fall;
   logic              sample_edge;

   spi_edge_detect #(.RST_VAL(CPOL)) u_sclk_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (sclk_f),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   // Reset value 0 means a CS already low at reset release never looks like a fall.
   spi_edge_detect #(.RST_VAL(1'b0)) u_cs_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (cs_n_f),
      .rise    (cs_rise),
      .fall    (cs_fall)
   );

   assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;

   always_comb begin
      if (MSB_FIRST) sr_next = {sr[DATA_W-2:0], mosi_f};
      else           sr_next = {mosi_f, sr[DATA_W-1:1]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         sr        <= '0;
         word_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         word_done <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cs_fall) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
                  sr      <= '0;
               end
            end
            ST_SHIFT: begin
               if (cs_rise) begin
                  state     <= ST_IDLE;
                  frame_err <= (bit_cnt != '0);
               end else if (sample_edge) begin
                  sr <= sr_next;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt   <= '0;
                     word_done <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // sr is stable for several clk after a completed word since SCLK edges are >= 4 clk apart.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (word_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= sr;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: doc/spi_slave_rx16.md
Name: spi_slave_rx16

Overview:
SPI slave receive stage that sits directly downstream of the per-pin glitch filters on SCLK, CS_n and MOSI. It consumes the filtered, clk-synchronous pin levels and recovers SPI clock edges by oversampling. It shifts in DATA_W-bit words and presents each one on a valid/ready output port with overrun and frame-error reporting. Typical setup: clk = 100 MHz, SPI SCLK at or below clk/8, so filtered edges are at least 4 clk apart.

Parameters:
DATA_W, 16, word length in bits (2..32)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = first received bit lands in rx_data[DATA_W-1]; 0 = it lands in rx_data[0]

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
sclk_f  in  1  filtered SCLK level, already synchronous to clk
cs_n_f  in  1  filtered chip select, active low, synchronous to clk
mosi_f  in  1  filtered MOSI level, synchronous to clk
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
rx_data  out  DATA_W  received word
rx_valid  out  1  rx_data holds an unconsumed word
overrun  out  1  one-clk pulse: a completed word was dropped
frame_err  out  1  one-clk pulse: CS deasserted mid-word
busy  out  1  state != IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n = 0:
  - rx_data = 0, rx_valid = 0, overrun = 0, frame_err = 0, busy = 0.
  - State = IDLE, bit_cnt = 0, shift register = 0.
  - sclk_d is set to CPOL and cs_d is set to 0. With cs_d = 0, a CS already held low at reset release does not start a frame; only a real 1->0 transition starts one.
- Edge detect:
  - sclk_d <= sclk_f and cs_d <= cs_n_f every clk.
  - rise = sclk_f & ~sclk_d; fall = ~sclk_f & sclk_d.
  - sample_edge = rise when CPOL == CPHA, otherwise fall.
  - cs_fall = ~cs_n_f & cs_d; cs_rise = cs_n_f & ~cs_d.
- FSM states:
  - IDLE -> SHIFT on cs_fall. Clear bit_cnt and the shift register on entry.
  - SHIFT, on sample_edge:
    - Shift mosi_f in. When MSB_FIRST = 1: sr <= {sr[DATA_W-2:0], mosi_f}. When MSB_FIRST = 0: sr <= {mosi_f, sr[DATA_W-1:1]}.
    - Increment bit_cnt.
  - SHIFT, on sample_edge with bit_cnt == DATA_W-1: the word is complete (see Output port). bit_cnt wraps to 0 and the FSM stays in SHIFT, so back-to-back words under a continuous CS are supported.
  - SHIFT, on cs_rise:
    - If bit_cnt != 0: pulse frame_err for one clk, discard the partial word, go to IDLE.
    - If bit_cnt == 0: go to IDLE silently.
  - cs_rise takes priority over a sample_edge in the same clk; that edge is ignored.
  - sample_edge while in IDLE is ignored.
- Output port:
  - Word complete and (rx_valid == 0 or rx_ready == 1): rx_data <= completed word and rx_valid <= 1 in the clk after the sample_edge. Latency is 2 clk from the sclk_f transition to rx_valid.
  - Word complete and rx_valid & ~rx_ready: drop the new word, keep the old rx_data and rx_valid, pulse overrun for one clk.
  - rx_valid & rx_ready with no word completing: rx_valid <= 0 next clk; rx_data holds its value.
  - rx_data is stable whenever rx_valid = 1.
- Width rule: bit_cnt is $clog2(DATA_W) bits. With DATA_W a power of 2, the wrap from DATA_W-1 to 0 is the natural rollover; otherwise bit_cnt is explicitly cleared at DATA_W-1.

Decomposition:
- spi_rx_pkg holds:
  - typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} spi_rx_state_t
  - function sample_on_rise(cpol, cpha)
  - localparam SPI_DEFAULT_W = 16
- Sub-module spi_edge_detect: one registered input; outputs rise and fall; reset value is a parameter. Instantiated twice, once for SCLK and once for CS.

Test Plan:
- Mode 0, MSB first, send 16'hA5C3 with SCLK = clk/8 and rx_ready = 1 -> rx_data = 16'hA5C3, rx_valid high exactly 1 clk, rx_valid rises 2 clk after the 16th sclk_f rise, no error pulses.
- CS held low, two words 16'h1234 then 16'hBEEF, rx_ready = 1 -> two valid beats in order, busy = 1 throughout, busy = 0 one clk after the CS rise.
- 9 bits sent, then CS rises -> one frame_err pulse, no rx_valid, state back to IDLE; next full frame 16'h0F0F is received correctly.
- rx_ready = 0, send 16'h1111 then 16'h2222 -> rx_data stays 16'h1111 with rx_valid = 1, one overrun pulse at completion of the second word; rx_ready = 1 for one clk -> rx_valid = 0.
- reset_n asserted after 8 bits of 16'hFFFF -> all outputs 0 immediately, asynchronously. After reset release with CS still low, no frame starts. A fresh CS fall followed by 16'h00FF -> rx_data = 16'h00FF.
- Build with CPOL = 1, CPHA = 1, MSB_FIRST = 0, send bits of 16'h8001 LSB first -> rx_data = 16'h8001; sampling occurs only on sclk_f rising edges.
